// File: rtl/ram_player.sv
// Streams a window of the simple dual-port RAM out on a valid/ready interface.
// Define RAM_PLAYER_LOOP_EN to add the `loop` port for continuous replay of the window.
module ram_player #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DEPTH_LOG2-1:0] start_addr,
  input  logic [DEPTH_LOG2:0]   length,
  input  logic                  abort,
  output logic [DEPTH_LOG2-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
`ifdef RAM_PLAYER_LOOP_EN
  ,
  input  logic                  loop
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   addr_q, addr_d;
  logic [DEPTH_LOG2:0]     rem_q, rem_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;
  logic                    can_load;

`ifdef RAM_PLAYER_LOOP_EN
  logic                    loop_q, loop_d;
  logic [DEPTH_LOG2-1:0]   base_addr_q, base_addr_d;
  logic [DEPTH_LOG2:0]     base_len_q, base_len_d;
`endif

  assign can_load  = !valid_q || out_ready;
  assign rd_addr   = addr_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = (state_q == RUN);
  assign done      = done_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = 1'b0;
`ifdef RAM_PLAYER_LOOP_EN
    loop_d      = loop_q;
    base_addr_d = base_addr_q;
    base_len_d  = base_len_q;
`endif
    if (abort) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_d = start_addr;
            rem_d  = length;
`ifdef RAM_PLAYER_LOOP_EN
            loop_d      = loop;
            base_addr_d = start_addr;
            base_len_d  = length;
`endif
            if (length != '0) state_d = RUN;
            else              done_d  = 1'b1;
          end
        end
        RUN: begin
          if (can_load) begin
            if (rem_q != '0) begin
              data_d  = rd_data;
              valid_d = 1'b1;
              addr_d  = addr_q + 1'b1;
              rem_d   = rem_q - 1'b1;
`ifdef RAM_PLAYER_LOOP_EN
              // Reload while taking the last word so the next cycle already
              // addresses the window start: replay continues without a bubble.
              if (loop_q && rem_q == (DEPTH_LOG2+1)'(1)) begin
                addr_d = base_addr_q;
                rem_d  = base_len_q;
              end
`endif
            end else if (valid_q) begin
              valid_d = 1'b0;
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef RAM_PLAYER_LOOP_EN
      loop_q      <= 1'b0;
      base_addr_q <= '0;
      base_len_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
`ifdef RAM_PLAYER_LOOP_EN
      loop_q      <= loop_d;
      base_addr_q <= base_addr_d;
      base_len_q  <= base_len_d;
`endif
    end
  end

endmodule
